// File: rtl/count_packetizer.sv
// Snapshots singles/coincidence counts on each integration strobe and streams them out
// as one framed, XOR-checksummed byte sequence over a valid/ready byte interface.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for integration strobe; strobe here captures counts
// S_SYNC0 | presenting sync byte 0xA5
// S_SYNC1 | presenting sync byte 0x5A
// S_SEQ   | presenting frame sequence number
// S_DROP  | presenting dropped-strobe count latched at capture
// S_WORD  | presenting count words, little-endian, word by word
// S_CHK   | presenting XOR checksum of SEQ, DROP and word bytes
module count_packetizer #(
   parameter int NUM_INPUTS      = 10,
   parameter int NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
   parameter int RESOLUTION      = 20,
   parameter int BYTES_PER_WORD  = (RESOLUTION + 7) / 8
) (
   input  logic                                  clk,
   input  logic                                  nrst,
   input  logic                                  integration_clk_pulse,
   input  logic [NUM_INPUTS*RESOLUTION-1:0]      singles_in,
   input  logic [NUM_CORRELATORS*RESOLUTION-1:0] coinc_in,
   output logic [7:0]                            tx_data,
   output logic                                  tx_valid,
   input  logic                                  tx_ready,
   output logic                                  busy,
   output logic                                  overrun
);

   localparam int NUM_WORDS = NUM_INPUTS + NUM_CORRELATORS;
   localparam int WIDX_W    = $clog2(NUM_WORDS + 1);
   localparam int BIDX_W    = $clog2(BYTES_PER_WORD + 1);
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC0,
      S_SYNC1,
      S_SEQ,
      S_DROP,
      S_WORD,
      S_CHK
   } state_t;

   state_t                state_q;
   logic [RESOLUTION-1:0] snap_q [NUM_WORDS];
   logic [WIDX_W-1:0]     widx_q;
   logic [BIDX_W-1:0]     bidx_q;
   logic [7:0]            seq_q;
   logic [7:0]            drop_cnt_q;
   logic [7:0]            drop_lat_q;
   logic [7:0]            chk_q;
   logic [7:0]            tx_data_q;
   logic                  tx_valid_q;
   logic                  overrun_q;

   logic                        hs_d;
   logic                        last_byte_d;
   logic [WIDX_W-1:0]           widx_d;
   logic [BIDX_W-1:0]           bidx_d;
   logic [WIDX_W-1:0]           sel_w_d;
   logic [BIDX_W-1:0]           sel_b_d;
   logic [BYTES_PER_WORD*8-1:0] word_pad_d;
   logic [7:0]                  next_byte_d;

   // next_byte_d is the byte to present after the current handshake: word 0 byte 0
   // when leaving DROP, otherwise the successor of the current word/byte position.
   always_comb begin
      hs_d        = tx_valid_q && tx_ready;
      last_byte_d = (widx_q == LAST_WORD) && (bidx_q == LAST_BYTE);
      widx_d      = widx_q;
      bidx_d      = bidx_q + 1'b1;
      if (bidx_q == LAST_BYTE) begin
         widx_d = widx_q + 1'b1;
         bidx_d = '0;
      end
      sel_w_d = '0;
      sel_b_d = '0;
      if (state_q == S_WORD && !last_byte_d) begin
         sel_w_d = widx_d;
         sel_b_d = bidx_d;
      end
      word_pad_d                   = '0;
      word_pad_d[RESOLUTION-1:0]   = snap_q[sel_w_d];
      next_byte_d                  = 8'(word_pad_d >> {sel_b_d, 3'b000});
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         widx_q     <= '0;
         bidx_q     <= '0;
         seq_q      <= 8'h00;
         drop_cnt_q <= 8'h00;
         drop_lat_q <= 8'h00;
         chk_q      <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         for (int k = 0; k < NUM_WORDS; k++) snap_q[k] <= '0;
      end else begin
         overrun_q <= 1'b0;
         if (integration_clk_pulse && state_q != S_IDLE) begin
            overrun_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
         end
         case (state_q)
            S_IDLE: begin
               if (integration_clk_pulse) begin
                  for (int k = 0; k < NUM_INPUTS; k++)
                     snap_q[k] <= singles_in[k*RESOLUTION +: RESOLUTION];
                  for (int k = 0; k < NUM_CORRELATORS; k++)
                     snap_q[NUM_INPUTS+k] <= coinc_in[k*RESOLUTION +: RESOLUTION];
                  drop_lat_q <= drop_cnt_q;
                  drop_cnt_q <= 8'h00;
                  chk_q      <= 8'h00;
                  widx_q     <= '0;
                  bidx_q     <= '0;
                  tx_data_q  <= 8'hA5;
                  tx_valid_q <= 1'b1;
                  state_q    <= S_SYNC0;
               end
            end
            S_SYNC0: begin
               if (hs_d) begin
                  tx_data_q <= 8'h5A;
                  state_q   <= S_SYNC1;
               end
            end
            S_SYNC1: begin
               if (hs_d) begin
                  tx_data_q <= seq_q;
                  state_q   <= S_SEQ;
               end
            end
            S_SEQ: begin
               if (hs_d) begin
                  chk_q     <= chk_q ^ tx_data_q;
                  tx_data_q <= drop_lat_q;
                  state_q   <= S_DROP;
               end
            end
            S_DROP: begin
               if (hs_d) begin
                  chk_q     <= chk_q ^ tx_data_q;
                  tx_data_q <= next_byte_d;
                  state_q   <= S_WORD;
               end
            end
            S_WORD: begin
               if (hs_d) begin
                  chk_q <= chk_q ^ tx_data_q;
                  if (last_byte_d) begin
                     tx_data_q <= chk_q ^ tx_data_q;
                     state_q   <= S_CHK;
                  end else begin
                     widx_q    <= widx_d;
                     bidx_q    <= bidx_d;
                     tx_data_q <= next_byte_d;
                  end
               end
            end
            S_CHK: begin
               if (hs_d) begin
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= 8'h00;
                  seq_q      <= seq_q + 8'd1;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               tx_valid_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;
   assign busy     = (state_q != S_IDLE);
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_count_packetizer.sv
// Randomized bench for count_packetizer: a frame-level reference model fills an expected
// byte queue on each accepted strobe; an independent monitor pops and compares handshakes.
module tb_count_packetizer;

   localparam int NI  = 2;
   localparam int NC  = NI * (NI - 1) / 2;
   localparam int RES = 12;
   localparam int BPW = (RES + 7) / 8;
   localparam int NW  = NI + NC;
   localparam int LEN = 5 + NW * BPW;

   typedef logic [NI*RES-1:0] sbus_t;
   typedef logic [NC*RES-1:0] cbus_t;

   logic       clk    = 1'b0;
   logic       nrst   = 1'b0;
   logic       strobe = 1'b0;
   logic       tx_ready = 1'b0;
   sbus_t      singles = '0;
   cbus_t      coinc   = '0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       busy;
   logic       overrun;

   count_packetizer #(
      .NUM_INPUTS (NI),
      .RESOLUTION (RES)
   ) dut (
      .clk                   (clk),
      .nrst                  (nrst),
      .integration_clk_pulse (strobe),
      .singles_in            (singles),
      .coinc_in              (coinc),
      .tx_data               (tx_data),
      .tx_valid              (tx_valid),
      .tx_ready              (tx_ready),
      .busy                  (busy),
      .overrun               (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_q [$];
   logic [7:0] log_d [$];
   int         log_c [$];

   int bytes_left = 0;
   int seq_m      = 0;
   int drop_m     = 0;
   int ovr_exp    = 0;
   int ovr_seen   = 0;
   int accept_cyc = -10;
   int rdy_mode   = 0;

   logic       prev_v = 1'b0;
   logic       prev_r = 1'b0;
   logic [7:0] prev_d = 8'h00;
   int         pos = 0;
   int         busy_chk_cyc = -10;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Whole frame computed from the capture values: sync, SEQ, DROP, LE words, XOR.
   function automatic void build_frame(input sbus_t s, input cbus_t c);
      int         vals [NW];
      logic [7:0] b;
      logic [7:0] chk;
      for (int w = 0; w < NI; w++) vals[w] = int'(s[w*RES +: RES]);
      for (int p = 0; p < NC; p++) vals[NI+p] = int'(c[p*RES +: RES]);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'(seq_m));
      exp_q.push_back(8'(drop_m));
      chk = 8'(seq_m) ^ 8'(drop_m);
      for (int w = 0; w < NW; w++) begin
         for (int k = 0; k < BPW; k++) begin
            b = 8'((vals[w] >> (8 * k)) & 255);
            chk ^= b;
            exp_q.push_back(b);
         end
      end
      exp_q.push_back(chk);
   endfunction

   initial begin : model
      forever begin
         @(negedge clk);
         if (nrst) begin
            if (strobe) begin
               if (bytes_left == 0) begin
                  build_frame(singles, coinc);
                  drop_m     = 0;
                  seq_m      = (seq_m + 1) % 256;
                  bytes_left = LEN;
                  accept_cyc = cyc;
               end else begin
                  if (drop_m < 255) drop_m++;
                  ovr_exp++;
               end
            end
            if (tx_valid && tx_ready && bytes_left > 0) bytes_left--;
         end
      end
   end

   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (nrst) begin
            if (overrun === 1'b1) ovr_seen++;
            if (cyc == accept_cyc + 1) check("first_byte_latency", tx_valid, 1);
            if (cyc == busy_chk_cyc) check("busy_after_chk", busy, 0);
            if (tx_valid) check("busy_while_valid", busy, 1);
            if (prev_v && !prev_r) begin
               check("hold_valid", tx_valid, 1);
               check("hold_data", tx_data, prev_d);
            end
            if (tx_valid && tx_ready) begin
               log_d.push_back(tx_data);
               log_c.push_back(cyc);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_byte: got 0x%0h expected no byte (cycle %0d)", tx_data, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_byte", tx_data, e);
                  pos++;
                  if (pos == LEN) begin
                     pos = 0;
                     busy_chk_cyc = cyc + 1;
                  end
               end
            end
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ($urandom % 2) == 0;
         2:       tx_ready = 1'b0;
         default: tx_ready = 1'b1;
      endcase
   endtask

   task automatic pulse();
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
   endtask

   task automatic rand_inputs();
      singles = sbus_t'($urandom);
      coinc   = cbus_t'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((bytes_left != 0 || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_done: timeout with %0d bytes outstanding, expected 0", bytes_left);
      end
      tick();
      tick();
   endtask

   task automatic clear_log();
      log_d.delete();
      log_c.delete();
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] golden [11];
      int         ovr0;
      int         n;
      golden = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'h05, 8'h00, 8'h91};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      nrst = 1'b1;
      rdy_mode = 0;
      tick();

      // Directed frame, ready tied high: exact bytes on consecutive cycles
      singles = {12'hABC, 12'h123};
      coinc   = 12'h005;
      tick();
      clear_log();
      pulse();
      wait_done(100);
      check("dir_len", log_d.size(), 11);
      for (int i = 0; i < 11 && i < log_d.size(); i++) begin
         check("dir_byte", log_d[i], golden[i]);
         check("dir_cycle", log_c[i], accept_cyc + 1 + i);
      end

      // Same data with random ready, inputs scrambled mid-frame
      rdy_mode = 1;
      tick();
      clear_log();
      pulse();
      for (int i = 0; i < 60; i++) begin
         rand_inputs();
         tick();
      end
      wait_done(400);
      check("rr_len", log_d.size(), 11);
      for (int i = 0; i < 11 && i < log_d.size(); i++) begin
         if (i == 2)       check("rr_seq", log_d[i], 8'h01);
         else if (i == 10) check("rr_chk", log_d[i], 8'h90);
         else              check("rr_byte", log_d[i], golden[i]);
      end

      // Two strobes inside a frame, then one after it
      ovr0 = ovr_seen;
      rand_inputs();
      pulse();
      repeat (3) tick();
      pulse();
      tick();
      pulse();
      wait_done(400);
      clear_log();
      rand_inputs();
      pulse();
      wait_done(400);
      check("ovr_two_pulses", ovr_seen - ovr0, 2);
      if (log_d.size() > 3) check("drop_two", log_d[3], 8'h02);
      else check("drop_two_len", log_d.size(), LEN);

      // Many frames: SEQ wraps, occasional dropped strobes
      for (int f = 0; f < 260; f++) begin
         rand_inputs();
         pulse();
         rand_inputs();
         if ($urandom % 4 == 0) begin
            repeat (2) tick();
            pulse();
         end
         wait_done(400);
      end

      // 300 dropped strobes saturate DROP at 0xFF
      rdy_mode = 2;
      rand_inputs();
      pulse();
      ovr0 = ovr_seen;
      strobe = 1'b1;
      repeat (300) tick();
      strobe = 1'b0;
      rdy_mode = 1;
      wait_done(400);
      check("ovr_300", ovr_seen - ovr0, 300);
      clear_log();
      rand_inputs();
      pulse();
      wait_done(400);
      if (log_d.size() > 3) check("drop_sat", log_d[3], 8'hFF);
      else check("drop_sat_len", log_d.size(), LEN);

      // Strobe held high: the CHK-handshake strobe drops, the next idle one is taken
      rdy_mode = 0;
      rand_inputs();
      strobe = 1'b1;
      repeat (40) tick();
      strobe = 1'b0;
      wait_done(400);

      // Reset in the middle of WORD
      rand_inputs();
      pulse();
      n = 0;
      while (bytes_left > 5 && n < 100) begin
         tick();
         n++;
      end
      check("reach_word", (bytes_left <= 5 && bytes_left > 1), 1);
      nrst = 1'b0;
      #1;
      check("midrst_tx_valid", tx_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_tx_data", tx_data, 8'h00);
      exp_q.delete();
      bytes_left   = 0;
      seq_m        = 0;
      drop_m       = 0;
      prev_v       = 1'b0;
      pos          = 0;
      busy_chk_cyc = -10;
      accept_cyc   = -10;
      tick();
      tick();
      nrst = 1'b1;
      tick();
      clear_log();
      rand_inputs();
      pulse();
      wait_done(400);
      check("post_rst_len", log_d.size(), LEN);
      for (int i = 0; i < 4 && i < log_d.size(); i++) check("post_rst_hdr", log_d[i], golden[i]);

      check("queue_empty", exp_q.size(), 0);
      check("ovr_total", ovr_seen, ovr_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
